// File: rtl/wic_pkg.sv
// Shared definitions for the wireless interface controller: encoded packet geometry,
// command/response IDs, default timing and the packet assembler state encoding.
package wic_pkg;

    localparam int ENCODED_PACKET_BYTES = 18;
    localparam int ENCODED_PACKET_WIDTH = 8 * ENCODED_PACKET_BYTES;

    localparam logic [15:0] ENCRYPT_ENABLE_DISABLE_RSP_ID = 16'h1;
    localparam logic [15:0] READ_YAW_CMD_RSP_ID           = 16'h2;

    localparam int DEFAULT_TIMEOUT = 4000000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } asm_state_t;

endpackage

// File: rtl/byte_timeout_counter.sv
// Idle-cycle counter between received bytes; pulses expired (combinationally) on the
// enabled cycle whose increment would reach TIMEOUT.
module byte_timeout_counter
    import wic_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    assign expired = enable && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ble_packet_assembler.sv
// Collects BLE UART RX bytes into one fixed-length encoded packet and holds it for the
// slave decoder under a valid/ack handshake, with inter-byte timeout and overrun flags.
module ble_packet_assembler
    import wic_pkg::*;
#(
    parameter int PACKET_BYTES = ENCODED_PACKET_BYTES,
    parameter int TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      soft_reset,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_valid,
    output logic [8*PACKET_BYTES-1:0] packet,
    output logic                      packet_valid,
    input  logic                      packet_ack,
    output logic [5:0]                byte_count,
    output logic                      busy,
    output logic                      timeout_error,
    output logic                      overflow_error
);

    localparam int PACKET_WIDTH = 8 * PACKET_BYTES;
    localparam logic [5:0] LAST_INDEX = 6'(PACKET_BYTES - 1);

    asm_state_t state;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;

    // Timer only advances on idle COLLECT cycles; a byte or any other state restarts it.
    assign timer_enable = (state == ST_COLLECT) && !rx_valid && !soft_reset;
    assign timer_clear  = soft_reset || rx_valid || (state != ST_COLLECT);

    byte_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // NOTE: the packet register is a plain flop vector, not a RAM, so it is safe to reset it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            packet         <= '0;
            byte_count     <= '0;
            packet_valid   <= 1'b0;
            busy           <= 1'b0;
            timeout_error  <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            timeout_error  <= 1'b0;
            overflow_error <= 1'b0;
            if (soft_reset) begin
                state        <= ST_IDLE;
                packet       <= '0;
                byte_count   <= '0;
                packet_valid <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_valid) begin
                            packet     <= {{(PACKET_WIDTH-8){1'b0}}, rx_byte};
                            byte_count <= 6'd1;
                            busy       <= 1'b1;
                            state      <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (rx_valid) begin
                            for (int k = 1; k < PACKET_BYTES; k++) begin
                                if (byte_count == 6'(k)) packet[8*k +: 8] <= rx_byte;
                            end
                            byte_count <= byte_count + 6'd1;
                            if (byte_count == LAST_INDEX) begin
                                packet_valid <= 1'b1;
                                busy         <= 1'b0;
                                state        <= ST_HOLD;
                            end
                        end else if (timer_expired) begin
                            timeout_error <= 1'b1;
                            packet        <= '0;
                            byte_count    <= '0;
                            busy          <= 1'b0;
                            state         <= ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (packet_ack) begin
                            packet_valid <= 1'b0;
                            if (rx_valid) begin
                                packet     <= {{(PACKET_WIDTH-8){1'b0}}, rx_byte};
                                byte_count <= 6'd1;
                                busy       <= 1'b1;
                                state      <= ST_COLLECT;
                            end else begin
                                byte_count <= '0;
                                state      <= ST_IDLE;
                            end
                        end else if (rx_valid) begin
                            overflow_error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
